// File: rtl/ct_unloader.sv
// ct_unloader
// -----------------------------------------------------------------------------
// Streams one ciphertext out of the CPU register file as an ordered sequence
// of residues on a valid/ready interface. Reads go through a dedicated
// synchronous read port (data one cycle after the strobe). A two-entry skid
// FIFO with credit-based issue keeps the stream bubble-free under full rate
// and lossless under any backpressure pattern.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low; 0 clears all state immediately
//   start          unload request, sampled only while busy=0
//   cipher_idx     ciphertext slot to unload, sampled with start
//   busy           high from the accepting edge through the edge issuing done
//   done           one-cycle pulse after the last beat handshakes
//   rf_rd_en       regfile read strobe
//   rf_rd_cipher   read address: ciphertext slot
//   rf_rd_poly     read address: polynomial (0 = A, 1 = B)
//   rf_rd_coeff    read address: coefficient
//   rf_rd_prime    read address: RNS prime
//   rf_rd_data     read data, valid one cycle after rf_rd_en
//   m_valid        output beat valid
//   m_ready        consumer ready
//   m_data         residue value (bit-exact copy of the stored value)
//   m_poly         beat tag: polynomial
//   m_coeff        beat tag: coefficient
//   m_prime        beat tag: prime
//   m_last         high on the final beat of the ciphertext
// -----------------------------------------------------------------------------
module ct_unloader #(
   parameter int NCOEFF   = 8,
   parameter int NPRIMES  = 4,
   parameter int NPOLY    = 2,
   parameter int NCIPHER  = 8,
   parameter int COEFF_W  = 32,
   localparam int CIPHER_W = (NCIPHER > 1) ? $clog2(NCIPHER) : 1,
   localparam int POLY_W   = (NPOLY   > 1) ? $clog2(NPOLY)   : 1,
   localparam int COEFF_IW = (NCOEFF  > 1) ? $clog2(NCOEFF)  : 1,
   localparam int PRIME_W  = (NPRIMES > 1) ? $clog2(NPRIMES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CIPHER_W-1:0] cipher_idx,
   output logic                busy,
   output logic                done,
   output logic                rf_rd_en,
   output logic [CIPHER_W-1:0] rf_rd_cipher,
   output logic [POLY_W-1:0]   rf_rd_poly,
   output logic [COEFF_IW-1:0] rf_rd_coeff,
   output logic [PRIME_W-1:0]  rf_rd_prime,
   input  logic [COEFF_W-1:0]  rf_rd_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [COEFF_W-1:0]  m_data,
   output logic [POLY_W-1:0]   m_poly,
   output logic [COEFF_IW-1:0] m_coeff,
   output logic [PRIME_W-1:0]  m_prime,
   output logic                m_last
);

   localparam logic [POLY_W-1:0]   POLY_MAX  = POLY_W'(NPOLY - 1);
   localparam logic [COEFF_IW-1:0] COEFF_MAX = COEFF_IW'(NCOEFF - 1);
   localparam logic [PRIME_W-1:0]  PRIME_MAX = PRIME_W'(NPRIMES - 1);
   localparam logic [POLY_W-1:0]   POLY_ONE  = POLY_W'(1);
   localparam logic [COEFF_IW-1:0] COEFF_ONE = COEFF_IW'(1);
   localparam logic [PRIME_W-1:0]  PRIME_ONE = PRIME_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Latched slot and the address walk counters
   logic [CIPHER_W-1:0] cipher_reg;
   logic [POLY_W-1:0]   poly_cnt;
   logic [COEFF_IW-1:0] coeff_cnt;
   logic [PRIME_W-1:0]  prime_cnt;
   logic                at_last;

   // Tags of the read whose data returns on the next cycle
   logic                flight;
   logic [POLY_W-1:0]   flight_poly;
   logic [COEFF_IW-1:0] flight_coeff;
   logic [PRIME_W-1:0]  flight_prime;
   logic                flight_last;

   // Two-entry output FIFO
   logic [COEFF_W-1:0]  fifo_data  [0:1];
   logic [POLY_W-1:0]   fifo_poly  [0:1];
   logic [COEFF_IW-1:0] fifo_coeff [0:1];
   logic [PRIME_W-1:0]  fifo_prime [0:1];
   logic                fifo_last  [0:1];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;

   logic                accept;
   logic                issue;
   logic                done_next;
   logic                push;
   logic                pop;
   logic                credit;
   logic [2:0]          occupancy;

   assign at_last = (poly_cnt == POLY_MAX) && (coeff_cnt == COEFF_MAX) &&
                    (prime_cnt == PRIME_MAX);

   assign m_valid = (count != 2'd0);
   assign pop     = m_valid && m_ready;
   assign push    = flight;

   // Buffered plus in-flight entries must never exceed the FIFO depth; a pop
   // on this edge frees the slot the new read will eventually occupy.
   assign occupancy = {1'b0, count} + {2'b00, flight};
   assign credit    = (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      issue      = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (credit) begin
               issue = 1'b1;
               if (at_last) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Finish on the edge that pops the final buffered beat so that
            // done appears in the cycle right after the m_last handshake.
            if (!flight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Slot latch and poly/coeff/prime address walk, prime innermost
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cipher_reg <= '0;
         poly_cnt   <= '0;
         coeff_cnt  <= '0;
         prime_cnt  <= '0;
      end else if (accept) begin
         cipher_reg <= cipher_idx;
         poly_cnt   <= '0;
         coeff_cnt  <= '0;
         prime_cnt  <= '0;
      end else if (issue) begin
         if (prime_cnt == PRIME_MAX) begin
            prime_cnt <= '0;
            if (coeff_cnt == COEFF_MAX) begin
               coeff_cnt <= '0;
               if (poly_cnt == POLY_MAX) begin
                  poly_cnt <= '0;
               end else begin
                  poly_cnt <= poly_cnt + POLY_ONE;
               end
            end else begin
               coeff_cnt <= coeff_cnt + COEFF_ONE;
            end
         end else begin
            prime_cnt <= prime_cnt + PRIME_ONE;
         end
      end
   end

   // In-flight read tracking: tags ride alongside the synchronous read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flight       <= 1'b0;
         flight_poly  <= '0;
         flight_coeff <= '0;
         flight_prime <= '0;
         flight_last  <= 1'b0;
      end else begin
         flight <= issue;
         if (issue) begin
            flight_poly  <= poly_cnt;
            flight_coeff <= coeff_cnt;
            flight_prime <= prime_cnt;
            flight_last  <= at_last;
         end
      end
   end

   // Output FIFO: push returning read data, pop on handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data[i]  <= '0;
            fifo_poly[i]  <= '0;
            fifo_coeff[i] <= '0;
            fifo_prime[i] <= '0;
            fifo_last[i]  <= 1'b0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr]  <= rf_rd_data;
            fifo_poly[wr_ptr]  <= flight_poly;
            fifo_coeff[wr_ptr] <= flight_coeff;
            fifo_prime[wr_ptr] <= flight_prime;
            fifo_last[wr_ptr]  <= flight_last;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Completion pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= done_next;
      end
   end

   assign busy         = (state != IDLE);
   assign rf_rd_en     = issue;
   assign rf_rd_cipher = cipher_reg;
   assign rf_rd_poly   = poly_cnt;
   assign rf_rd_coeff  = coeff_cnt;
   assign rf_rd_prime  = prime_cnt;

   assign m_data  = fifo_data[rd_ptr];
   assign m_poly  = fifo_poly[rd_ptr];
   assign m_coeff = fifo_coeff[rd_ptr];
   assign m_prime = fifo_prime[rd_ptr];
   assign m_last  = m_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_ct_unloader.sv
// tb_ct_unloader
// Drives ct_unloader against a behavioural regfile model with a synchronous
// read port. Expected beat streams are built from the residue rules of each
// slot and consumed by a monitor as beats handshake.
module tb_ct_unloader;

   localparam int NCOEFF  = 8;
   localparam int NPRIMES = 4;
   localparam int NPOLY   = 2;
   localparam int NCIPHER = 8;
   localparam int COEFF_W = 32;
   localparam int NBEATS  = NPOLY * NCOEFF * NPRIMES;
   localparam int BUDGET  = 2000;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [2:0]         cipherIdx = 3'd0;
   logic               busy;
   logic               done;
   logic               rfRdEn;
   logic [2:0]         rfRdCipher;
   logic [0:0]         rfRdPoly;
   logic [2:0]         rfRdCoeff;
   logic [1:0]         rfRdPrime;
   logic [COEFF_W-1:0] rfRdData = '0;
   logic               mValid;
   logic               mReady = 1'b0;
   logic [COEFF_W-1:0] mData;
   logic [0:0]         mPoly;
   logic [2:0]         mCoeff;
   logic [1:0]         mPrime;
   logic               mLast;

   ct_unloader #(
      .NCOEFF(NCOEFF), .NPRIMES(NPRIMES), .NPOLY(NPOLY),
      .NCIPHER(NCIPHER), .COEFF_W(COEFF_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cipher_idx(cipherIdx),
      .busy(busy), .done(done), .rf_rd_en(rfRdEn),
      .rf_rd_cipher(rfRdCipher), .rf_rd_poly(rfRdPoly),
      .rf_rd_coeff(rfRdCoeff), .rf_rd_prime(rfRdPrime),
      .rf_rd_data(rfRdData), .m_valid(mValid), .m_ready(mReady),
      .m_data(mData), .m_poly(mPoly), .m_coeff(mCoeff),
      .m_prime(mPrime), .m_last(mLast)
   );

   always #5 clk = ~clk;

   // Regfile contents and its synchronous read port
   logic [COEFF_W-1:0] mem [NCIPHER][NPOLY][NCOEFF][NPRIMES];

   always @(posedge clk) begin
      if (rfRdEn) rfRdData <= mem[rfRdCipher][rfRdPoly][rfRdCoeff][rfRdPrime];
   end

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [63:0] packBeat(input logic [31:0] d, input logic [0:0] p,
                                            input logic [2:0] c, input logic [1:0] r,
                                            input logic last);
      return {25'd0, d, p, c, r, last};
   endfunction

   // Residue rules: slot 0 is the preloaded CT0, slot 2 is the CT0+CT1 result
   function automatic logic [31:0] ct0Value(input int p, input int c, input int r);
      return (p == 0) ? 32'(10 + c + r) : 32'(20 + 2 * c + r);
   endfunction

   function automatic logic [31:0] expectedResidue(input int slot, input int p,
                                                   input int c, input int r);
      if (slot == 0) return ct0Value(p, c, r);
      if (slot == 2) return ct0Value(p, c, r) + mem[1][p][c][r];
      return mem[slot][p][c][r];
   endfunction

   function automatic logic readyFor(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc < 5) ? 1'b0 : cyc[0];
         default: return 1'(($urandom_range(0, 1)));
      endcase
   endfunction

   // Monitor: beat order/value, stall stability, credit bound, done pulses
   logic [63:0] expQ [$];
   int          beatCount = 0;
   int          doneCount = 0;
   int          occ = 0;
   logic        prevStall = 1'b0;
   logic [63:0] heldBeat = '0;
   logic [63:0] curBeat;

   always @(negedge clk) begin
      if (!reset) begin
         occ       = 0;
         prevStall = 1'b0;
      end else begin
         curBeat = packBeat(mData, mPoly, mCoeff, mPrime, mLast);
         if (prevStall) begin
            checkOutput("stallValid", 64'(mValid), 64'd1);
            checkOutput("stallHold", curBeat, heldBeat);
         end
         if (done) doneCount++;
         if (mValid && mReady) begin
            beatCount++;
            if (expQ.size() == 0) checkOutput("extraBeat", 64'd1, 64'd0);
            else checkOutput("beat", curBeat, expQ.pop_front());
         end
         occ = occ + int'(rfRdEn) - int'(mValid && mReady);
         if (busy) checkOutput("outstanding<=2", 64'(occ <= 2), 64'd1);
         prevStall = mValid && !mReady;
         heldBeat  = curBeat;
      end
   end

   // One unload: start on the next edge, run until done or the budget runs out.
   // busyStartAt >= 0 pulses start for slot 1 at that cycle; resetAfter > 0
   // pulls reset low once that many beats have transferred.
   task automatic applyStimulus(input int slot, input int mode,
                                input int busyStartAt, input int resetAfter);
      int   cycles;
      logic finished;
      expQ.delete();
      for (int p = 0; p < NPOLY; p++)
         for (int c = 0; c < NCOEFF; c++)
            for (int r = 0; r < NPRIMES; r++)
               expQ.push_back(packBeat(expectedResidue(slot, p, c, r), p[0:0], c[2:0],
                                       r[1:0], (p == NPOLY-1) && (c == NCOEFF-1) &&
                                       (r == NPRIMES-1)));
      start     = 1'b1;
      cipherIdx = 3'(slot);
      mReady    = readyFor(mode, 0);
      @(posedge clk); #1;
      start     = 1'b0;
      beatCount = 0;
      doneCount = 0;
      checkOutput("busyAfterStart", 64'(busy), 64'd1);
      cycles   = 0;
      finished = 1'b0;
      while (!finished && cycles < BUDGET) begin
         mReady = readyFor(mode, cycles);
         start  = (cycles == busyStartAt);
         if (cycles == busyStartAt) cipherIdx = 3'd1;
         @(posedge clk); #1;
         cycles++;
         if (resetAfter > 0 && beatCount >= resetAfter) begin
            reset = 1'b0;
            #1;
            checkOutput("resetBeats", 64'(beatCount), 64'(resetAfter));
            checkOutput("resetValid", 64'(mValid), 64'd0);
            checkOutput("resetBusy", 64'(busy), 64'd0);
            checkOutput("resetDone", 64'(done), 64'd0);
            checkOutput("resetRdEn", 64'(rfRdEn), 64'd0);
            @(posedge clk); #1;
            reset = 1'b1;
            start = 1'b0;
            expQ.delete();
            return;
         end
         if (done) finished = 1'b1;
      end
      start = 1'b0;
      checkOutput("doneSeen", 64'(finished), 64'd1);
      if (mode == 0) checkOutput("startToDone", 64'(cycles), 64'(NBEATS + 2));
      checkOutput("beatCount", 64'(beatCount), 64'(NBEATS));
      checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
      checkOutput("busyAtDone", 64'(busy), 64'd0);
      @(negedge clk); #1;
      checkOutput("singleDone", 64'(doneCount), 64'd1);
   endtask

   initial begin
      for (int s = 0; s < NCIPHER; s++)
         for (int p = 0; p < NPOLY; p++)
            for (int c = 0; c < NCOEFF; c++)
               for (int r = 0; r < NPRIMES; r++) begin
                  if (s == 0)      mem[s][p][c][r] = ct0Value(p, c, r);
                  else if (s == 1) mem[s][p][c][r] = 32'($urandom_range(0, 1000));
                  else             mem[s][p][c][r] = $urandom;
               end
      // The CPU's OP_CT_CT_ADD result lands in slot 2
      for (int p = 0; p < NPOLY; p++)
         for (int c = 0; c < NCOEFF; c++)
            for (int r = 0; r < NPRIMES; r++)
               mem[2][p][c][r] = mem[0][p][c][r] + mem[1][p][c][r];

      #12;
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstRdEn", 64'(rfRdEn), 64'd0);
      checkOutput("rstValid", 64'(mValid), 64'd0);
      checkOutput("rstLast", 64'(mLast), 64'd0);
      checkOutput("rstData", 64'(mData), 64'd0);
      checkOutput("rstTags", 64'({mPoly, mCoeff, mPrime}), 64'd0);
      checkOutput("rstAddr", 64'({rfRdCipher, rfRdPoly, rfRdCoeff, rfRdPrime}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      $display("[TB] full-rate unload of CT0");
      applyStimulus(0, 0, -1, 0);
      $display("[TB] back-to-back unload with backpressure");
      applyStimulus(0, 1, -1, 0);
      $display("[TB] start while busy");
      applyStimulus(0, 2, 10, 0);
      $display("[TB] CPU result readout");
      applyStimulus(2, 2, -1, 0);
      $display("[TB] reset mid-unload and restart");
      applyStimulus(0, 0, -1, 3);
      applyStimulus(0, 0, -1, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idleBusy", 64'(busy), 64'd0);
      $display("[TB] random slots under random backpressure");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(int'($urandom_range(0, NCIPHER - 1)), 2, -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
